// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner running 32-step shift-add multiply and restoring divide
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        stall,
  output logic        done
);
  localparam logic [1:0] IDLE = 2'd0, PREP = 2'd1, ITER = 2'd2, FIX = 2'd3;
  logic [1:0]  state, op_r;
  logic [31:0] a_r, b_r, ua, ub, q, abs_a, abs_b, q_n, fix_hi, fix_lo;
  logic [32:0] r, r_n, mr, rs, trial;
  logic [63:0] prod, prod_s;
  logic [4:0]  cnt;
  logic        neg_q, neg_r, is_div, sgn;
  assign is_div = op_r[1];
  assign sgn    = ~op_r[0];
  assign stall  = start | busy;
  assign abs_a  = (sgn & a_r[31]) ? -a_r : a_r;
  assign abs_b  = (sgn & b_r[31]) ? -b_r : b_r;
  // r/q hold acc/mplr while multiplying and rem/quo while dividing
  always_comb begin
    mr     = q[0] ? r + {1'b0, ua} : r;
    rs     = {r[31:0], q[31]};
    trial  = rs - {1'b0, ub};
    r_n    = is_div ? (trial[32] ? rs : trial) : {1'b0, mr[32:1]};
    q_n    = is_div ? {q[30:0], ~trial[32]} : {mr[0], q[31:1]};
    prod   = {r[31:0], q};
    prod_s = neg_q ? -prod : prod;
    fix_hi = is_div ? (b_r == 32'd0 ? a_r : (neg_r ? -r[31:0] : r[31:0])) : prod_s[63:32];
    fix_lo = is_div ? (b_r == 32'd0 ? 32'hFFFF_FFFF : (neg_q ? -q : q)) : prod_s[31:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      op_r  <= 2'd0;
      a_r   <= 32'd0;
      b_r   <= 32'd0;
      ua    <= 32'd0;
      ub    <= 32'd0;
      q     <= 32'd0;
      r     <= 33'd0;
      cnt   <= 5'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      HI    <= 32'd0;
      LO    <= 32'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            a_r   <= src_a;
            b_r   <= src_b;
            busy  <= 1'b1;
            state <= PREP;
          end else begin
            if (hi_we) HI <= wdata;
            if (lo_we) LO <= wdata;
          end
        end
        PREP: begin
          ua    <= abs_a;
          ub    <= abs_b;
          neg_q <= sgn & (a_r[31] ^ b_r[31]);
          neg_r <= sgn & a_r[31];
          cnt   <= 5'd0;
          r     <= 33'd0;
          q     <= is_div ? abs_a : abs_b;
          state <= ITER;
        end
        ITER: begin
          r     <= r_n;
          q     <= q_n;
          cnt   <= cnt + 5'd1;
          state <= (cnt == 5'd31) ? FIX : ITER;
        end
        default: begin
          HI    <= fix_hi;
          LO    <= fix_lo;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: vector table plus scoreboard checking of muldiv_ctrl
module tb_muldiv_ctrl;
  logic        clk, rst, start, hi_we, lo_we, busy, stall, done;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata, HI, LO;
  int          n_chk = 0, n_pass = 0;
  logic [63:0] sb[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    int          wr;
  } vec_t;
  vec_t vecs[9];

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .HI(HI), .LO(LO),
    .busy(busy), .stall(stall), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, qq, rr;
    logic [63:0] ua, ub, uq, ur;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    if (o == 2'd0) return 64'(sa * sbv);
    if (o == 2'd1) return ua * ub;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (o == 2'd2) begin
      qq = sa / sbv;
      rr = sa % sbv;
      return {rr[31:0], qq[31:0]};
    end
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  // wr: 0 = no write, 1 = lo_we alongside start, 2 = hi_we held while busy
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int wr, input string nm);
    logic [31:0] ph, pl;
    logic [63:0] e;
    int cyc, bc;
    ph = HI;
    pl = LO;
    op = o; src_a = a; src_b = b; start = 1'b1;
    if (wr == 1) begin lo_we = 1'b1; wdata = 32'h5555_AAAA; end
    sb.push_back({eh, el});
    #1 chk({nm, " stall_on_start"}, 64'(stall), 64'd1);
    cyc = 0;
    bc  = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      lo_we = 1'b0;
      hi_we = (wr == 2);
      if (wr == 2) wdata = 32'hDEAD_BEEF;
      if (busy) bc++;
      if (cyc == 1 || cyc == 20) begin
        chk({nm, " hi_hold"}, 64'(HI), 64'(ph));
        chk({nm, " lo_hold"}, 64'(LO), 64'(pl));
        chk({nm, " stall_busy"}, 64'(stall), 64'd1);
      end
    end while (!done && cyc < 100);
    hi_we = 1'b0;
    chk({nm, " latency"}, 64'(cyc), 64'd35);
    chk({nm, " busy_cycles"}, 64'(bc), 64'd34);
    chk({nm, " busy_low_at_done"}, 64'(busy), 64'd0);
    if (sb.size() == 0) chk({nm, " scoreboard_empty"}, 64'd1, 64'd0);
    else begin
      e = sb.pop_front();
      if (done) begin
        chk({nm, " HI"}, 64'(HI), 64'(e[63:32]));
        chk({nm, " LO"}, 64'(LO), 64'(e[31:0]));
      end else chk({nm, " timeout"}, 64'(done), 64'd1);
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [63:0] re;
    vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0};
    vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1};
    vecs[2] = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        2};
    vecs[3] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0};
    vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 0};
    vecs[5] = '{2'd3, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 0};
    vecs[6] = '{2'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 0};
    vecs[7] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         0};
    vecs[8] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 2};
    rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; op = 2'd0;
    src_a = 32'd0; src_b = 32'd0; wdata = 32'd0;
    #1;
    chk("reset HI", 64'(HI), 64'd0);
    chk("reset LO", 64'(LO), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi", 64'(HI), 64'hCAFE_F00D);
    chk("mtlo", 64'(LO), 64'hCAFE_F00D);
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].wr, $sformatf("vec%0d", i));
      if (i == 0) begin
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
      end
    end
    op = 2'd1; src_a = 32'hFFFF_FFFF; src_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("midop busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst HI", 64'(HI), 64'd0);
    chk("midrst LO", 64'(LO), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(2'd1, 32'd6, 32'd7, 32'd0, 32'd42, 0, "after_reset");
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      re = model(ro, ra, rb);
      run_op(ro, ra, rb, re[63:32], re[31:0], 0, $sformatf("rand%0d", i));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
